// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-side command/response signals and the APB master port
// shared by the arbiter and its environment.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;

    // Arbiter side: drives the APB bus and requester responses.
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    // Environment side: requesters plus the APB slave.
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB slave among NUM_REQ requesters,
// sequencing IDLE/SETUP/ACCESS with a bounded PREADY wait.
module apb_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    apb_req_arbiter_if.master bus
);
    localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                grant_any;
    logic [GW-1:0]       grant_idx;

    // Round-robin pick: first valid requester after the last one served.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!grant_any && bus.req_valid[(int'(last_grant_q) + i) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_idx = GW'((int'(last_grant_q) + i) % NUM_REQ);
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE && grant_any) ? (NUM_REQ'(1) << grant_idx) : '0;

    // Next-state and registered-output logic for the APB sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (grant_any) begin
                    pwrite_d     = bus.req_write[grant_idx];
                    paddr_d      = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
                    pwdata_d     = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
                    psel_d       = 1'b1;
                    last_grant_d = grant_idx;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << last_grant_q;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // A stalled slave is abandoned once the wait budget is spent.
                    if (TIMEOUT != 0 && cnt_q == CW'(TO_LIM)) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = NUM_REQ'(1) << last_grant_q;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset also abandons any in-flight transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            cnt_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with two requesters and TIMEOUT=16.
module tb_apb_req_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    apb_req_arbiter_if #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(32)) bus ();

    apb_req_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Step to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin failures++; $display("FAIL reset_apb psel=%b penable=%b exp 0/0", bus.PSEL, bus.PENABLE); end
        checks++; if (bus.PADDR !== 4'h0 || bus.PWDATA !== 32'h0 || bus.PWRITE !== 1'b0) begin failures++; $display("FAIL reset_bus paddr=%h pwdata=%h pwrite=%b exp 0", bus.PADDR, bus.PWDATA, bus.PWRITE); end
        checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp vld=%b err=%b rdata=%h exp 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_write();
        tick();
        bus.req_valid = 2'b01;
        bus.req_write = 2'b01;
        bus.req_addr  = {4'h0, 4'h3};
        bus.req_wdata = {32'h0, 32'hDEADBEEF};
        bus.PREADY    = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL wr_grant got=%b exp=01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        #1;
        checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0) begin failures++; $display("FAIL wr_setup psel=%b penable=%b exp 1/0", bus.PSEL, bus.PENABLE); end
        checks++; if (bus.PADDR !== 4'h3 || bus.PWDATA !== 32'hDEADBEEF || bus.PWRITE !== 1'b1) begin failures++; $display("FAIL wr_setup_bus paddr=%h pwdata=%h pwrite=%b exp 3/deadbeef/1", bus.PADDR, bus.PWDATA, bus.PWRITE); end
        tick();
        #1;
        checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin failures++; $display("FAIL wr_access psel=%b penable=%b exp 1/1", bus.PSEL, bus.PENABLE); end
        checks++; if (bus.PADDR !== 4'h3 || bus.PWDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_access_bus paddr=%h pwdata=%h exp 3/deadbeef", bus.PADDR, bus.PWDATA); end
        tick();
        #1;
        checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL wr_rsp vld=%b err=%b rdata=%h exp 01/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin failures++; $display("FAIL wr_done psel=%b penable=%b exp 0/0", bus.PSEL, bus.PENABLE); end
        tick();
        #1;
        checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL wr_pulse got=%b exp=00", bus.rsp_valid); end
        checks++; if (bus.PADDR !== 4'h3 || bus.PWDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_idle_hold paddr=%h pwdata=%h exp 3/deadbeef", bus.PADDR, bus.PWDATA); end
    endtask

    task automatic test_read_wait();
        int pen = 0;
        tick();
        bus.req_valid = 2'b10;
        bus.req_write = 2'b00;
        bus.req_addr  = {4'hA, 4'h0};
        bus.PREADY    = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL rd_grant got=%b exp=10", bus.req_ready); end
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) bus.req_valid = 2'b00;
            if (c == 4) begin
                bus.PREADY = 1'b1;
                bus.PRDATA = 32'h12345678;
            end
            #1;
            if (bus.PENABLE === 1'b1) pen++;
            if (c == 1) begin
                checks++; if (bus.PADDR !== 4'hA || bus.PWRITE !== 1'b0) begin failures++; $display("FAIL rd_setup_bus paddr=%h pwrite=%b exp a/0", bus.PADDR, bus.PWRITE); end
            end
            if (c == 4) begin
                checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL rd_early_rsp got=%b exp=00", bus.rsp_valid); end
            end
        end
        checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'h12345678 || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL rd_rsp vld=%b rdata=%h err=%b exp 10/12345678/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
        checks++; if (pen !== 3) begin failures++; $display("FAIL rd_penable_cycles got=%0d exp=3", pen); end
        bus.PRDATA = 32'h0;
    endtask

    task automatic test_back_to_back();
        int grants = 0;
        int n0 = 0;
        int n1 = 0;
        int cyc = 0;
        int last_cyc = 0;
        logic [1:0] prev = 2'b00;
        logic [1:0] exp;
        bus.PREADY    = 1'b1;
        bus.PRDATA    = 32'h0BADF00D;
        bus.req_write = 2'b00;
        while (grants < 8 && cyc < 60) begin
            tick();
            cyc++;
            bus.req_valid = {(n1 < 4), (n0 < 4)};
            #1;
            if (bus.req_ready !== 2'b00) begin
                exp = (grants % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (bus.req_ready !== exp) begin failures++; $display("FAIL b2b_order grant=%0d got=%b exp=%b", grants, bus.req_ready, exp); end
                if (grants > 0) begin
                    checks++; if (cyc - last_cyc !== 3) begin failures++; $display("FAIL b2b_spacing grant=%0d got=%0d exp=3", grants, cyc - last_cyc); end
                    checks++; if (bus.rsp_valid !== prev) begin failures++; $display("FAIL b2b_overlap grant=%0d rsp=%b exp=%b", grants, bus.rsp_valid, prev); end
                end
                if (bus.req_ready[0]) n0++;
                if (bus.req_ready[1]) n1++;
                prev = bus.req_ready;
                last_cyc = cyc;
                grants++;
            end
        end
        checks++; if (grants !== 8) begin failures++; $display("FAIL b2b_budget grants=%0d exp=8", grants); end
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        #1;
        checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL b2b_last_rsp vld=%b rdata=%h exp 10/0badf00d", bus.rsp_valid, bus.rsp_rdata); end
    endtask

    task automatic test_timeout();
        int pen = 0;
        bit done = 0;
        tick();
        bus.req_valid = 2'b01;
        bus.req_write = 2'b00;
        bus.req_addr  = {4'h0, 4'h5};
        bus.PREADY    = 1'b0;
        bus.PRDATA    = 32'hCAFEF00D;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL to_grant got=%b exp=01", bus.req_ready); end
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            bus.req_valid = 2'b00;
            #1;
            if (bus.PENABLE === 1'b1) pen++;
            if (bus.rsp_valid !== 2'b00) done = 1;
        end
        checks++; if (!done) begin failures++; $display("FAIL to_budget no rsp within 40 cycles"); end
        checks++; if (pen !== 16) begin failures++; $display("FAIL to_penable_cycles got=%0d exp=16", pen); end
        checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.PSEL !== 1'b0) begin failures++; $display("FAIL to_rsp vld=%b err=%b rdata=%h psel=%b exp 01/1/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.PSEL); end
        bus.req_valid = 2'b01;
        bus.req_write = 2'b01;
        bus.req_addr  = {4'h0, 4'h7};
        bus.req_wdata = {32'h0, 32'h00000055};
        bus.PREADY    = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL to_next_grant got=%b exp=01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        #1;
        checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL to_next_rsp vld=%b err=%b rdata=%h exp 01/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.req_valid = 2'b10;
        bus.req_write = 2'b00;
        bus.req_addr  = {4'hA, 4'h0};
        bus.PREADY    = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL rm_grant got=%b exp=10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (bus.PENABLE !== 1'b1) begin failures++; $display("FAIL rm_in_access penable=%b exp=1", bus.PENABLE); end
        tick();
        rst = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_write = 2'b00;
        bus.req_addr  = {4'h9, 4'h6};
        bus.PREADY    = 1'b1;
        bus.PRDATA    = 32'hA5A5A5A5;
        #1;
        checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.PADDR !== 4'h0 || bus.PWDATA !== 32'h0 || bus.PWRITE !== 1'b0) begin failures++; $display("FAIL rm_apb psel=%b pen=%b paddr=%h pwdata=%h pwrite=%b exp 0", bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA, bus.PWRITE); end
        checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL rm_rsp vld=%b err=%b rdata=%h exp 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL rm_first_grant got=%b exp=01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b10;
        #1;
        checks++; if (bus.rsp_valid !== 2'b00 || bus.PADDR !== 4'h6) begin failures++; $display("FAIL rm_setup rsp=%b paddr=%h exp 00/6", bus.rsp_valid, bus.PADDR); end
        tick();
        #1;
        checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL rm_no_stale_rsp got=%b exp=00", bus.rsp_valid); end
        tick();
        #1;
        checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL rm_rsp0 vld=%b rdata=%h exp 01/a5a5a5a5", bus.rsp_valid, bus.rsp_rdata); end
        checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL rm_second_grant got=%b exp=10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- APB master-side controller that shares one APB slave port (4-bit address, 32-bit data, PREADY handshake) among NUM_REQ internal requesters.
- Accepts single read/write commands on per-requester valid/ready ports and arbitrates round-robin.
- Sequences the APB IDLE/SETUP/ACCESS protocol, returns read data and completion status to the granted requester.
- Bounds slave stalls with a PREADY timeout.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 4, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester command valid.
- req_ready  output  NUM_REQ  per-requester command accepted (one-hot or zero).
- req_write  input  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing.
- rsp_valid  output  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  output  DATA_W  read data, valid with rsp_valid.
- rsp_err  output  1  1 = transfer aborted by timeout, valid with rsp_valid.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB write control.
- PADDR  output  ADDR_W  APB address.
- PWDATA  output  DATA_W  APB write data.
- PRDATA  input  DATA_W  APB read data.
- PREADY  input  1  APB ready.

Behaviour:
- Reset values: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, last_grant=NUM_REQ-1 (requester 0 wins first).
- rst mid-transfer: next edge forces the above values. No rsp_valid is issued for the killed transfer.
- Requester rule: req_write, req_addr and req_wdata are held stable while req_valid=1 until req_ready=1.
- All APB and rsp outputs are registered. req_ready is combinational from state and req_valid.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, grant g = first set index searching from last_grant+1 with wrap modulo NUM_REQ.
  - req_ready[g]=1 this cycle.
  - Next edge: latch PWRITE/PADDR/PWDATA from requester g, PSEL=1, PENABLE=0, last_grant=g, state=SETUP.
  - If no req_valid is set, outputs hold and PSEL=0.
- SETUP: exactly one cycle. Next edge: PENABLE=1, wait counter=0, state=ACCESS.
- ACCESS, PREADY=1:
  - Next edge: PSEL=0, PENABLE=0, rsp_valid[g]=1, rsp_err=0, state=IDLE.
  - rsp_rdata = PRDATA for a read; rsp_rdata = 0 for a write.
- ACCESS, PREADY=0:
  - Wait counter increments.
  - If TIMEOUT!=0 and counter == TIMEOUT-1, next edge: PSEL=0, PENABLE=0, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, state=IDLE.
  - A PREADY=1 in the same cycle as the timeout limit wins: normal completion.
- rsp_valid is a single-cycle pulse; it clears at the next edge.
- Back-to-back: the IDLE cycle carrying rsp_valid may grant a new command. Minimum 3 cycles per transfer, so peak throughput is one transfer per 3 cycles.
- PADDR, PWDATA and PWRITE hold their last values while idle. They never change while PSEL=1.
- Exactly one outstanding transfer. req_ready is 0 in SETUP and ACCESS.
- Fairness: a continuously requesting set of requesters is served in strict rotation. No requester waits more than NUM_REQ-1 transfers.

Test Plan:
- Write, no wait: req0 write addr 4'h3, data 32'hDEADBEEF, PREADY=1.
  - req_ready[0] at cycle T.
  - PSEL=1/PENABLE=0 at T+1.
  - PENABLE=1 at T+2.
  - rsp_valid[0]=1, rsp_err=0, rsp_rdata=0 at T+3.
  - PADDR=3, PWDATA=DEADBEEF held T+1..T+2.
- Read with waits: req1 read addr 4'hA, PREADY low for 2 ACCESS cycles, PRDATA=32'h12345678 on the ready cycle.
  - rsp_valid[1]=1 and rsp_rdata=12345678 at T+5.
  - PENABLE high for exactly 3 cycles.
- Contention: req0 and req1 held valid continuously for 4 commands each.
  - Grant order 0,1,0,1,...
  - New grant in the same cycle as the previous rsp_valid.
  - One transfer every 3 cycles.
- Timeout: TIMEOUT=16, PREADY stuck 0, req0 read.
  - PENABLE high exactly 16 cycles.
  - Then rsp_valid[0]=1, rsp_err=1, rsp_rdata=0, PSEL=0.
  - Next request completes normally.
- Reset mid-ACCESS: assert rst for 1 cycle during ACCESS.
  - Next edge: PSEL=0, PENABLE=0, all outputs at reset values.
  - No rsp_valid.
  - After release, req1 and req0 both valid: req0 granted first.
